// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage of the in-order core.
// Issues loads/stores to a handshaked data memory, produces a one-cycle
// writeback strobe and a one-cycle redirect pulse for taken control transfers.
// Optional feature: define MEM_ALIGN_CHECK_EN to reject misaligned memory ops
// (no request, misalign_err pulse). Undefined: low address bits are forced to 00.

module mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] alu_result,
    input  logic [31:0] read_data_2,
    input  logic [31:0] pc_addimm,
    input  logic        zero_flag,
    input  logic [1:0]  pc_src,
    input  logic        reg_write,
    input  logic [1:0]  mem_to_reg,
    input  logic        mem_write,
    input  logic        branch,
    input  logic [2:0]  b_type,
    input  logic [4:0]  reg_write_addr,
    input  logic [31:0] pc_add4,
    output logic        stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic        wb_reg_write,
    output logic [4:0]  wb_addr,
    output logic [31:0] wb_data,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        misalign_err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic        isLoad;
    logic        isMemOp;
    logic        accept;
    logic        misaligned;
    logic        issueMem;
    logic        taken;
    logic [31:0] redirTarget;
    logic [31:0] aluWbData;
    logic [31:0] memWbData;
    logic        capIsLoad;

    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] pcAdd4_q;
    logic [31:0] pcAddImm_q;
    logic        regWrite_q;
    logic [1:0]  memToReg_q;
    logic [4:0]  rd_q;

    logic        wbValid_q;
    logic        wbRegWrite_q;
    logic [4:0]  wbAddr_q;
    logic [31:0] wbData_q;
    logic        redirValid_q;
    logic [31:0] redirPc_q;

    // Decode the incoming bundle: memory-op class, acceptance, branch outcome and writeback value.
    always_comb begin
        isLoad   = reg_write && (mem_to_reg == 2'b01);
        isMemOp  = mem_write || isLoad;
        accept   = (state_q == IDLE) && in_valid;
`ifdef MEM_ALIGN_CHECK_EN
        misaligned = isMemOp && (alu_result[1:0] != 2'b00);
`else
        misaligned = 1'b0;
`endif
        issueMem = accept && isMemOp && !misaligned;

        taken = 1'b0;
        case (pc_src)
            2'b10, 2'b11: taken = 1'b1;
            2'b01: taken = branch && (((b_type == 3'b000) && zero_flag) ||
                                      ((b_type == 3'b001) && !zero_flag));
            default: taken = 1'b0;
        endcase

        redirTarget = (pc_src == 2'b11) ? {alu_result[31:1], 1'b0} : pc_addimm;

        aluWbData = 32'h0;
        case (mem_to_reg)
            2'b00: aluWbData = alu_result;
            2'b10: aluWbData = pc_add4;
            2'b11: aluWbData = pc_addimm;
            default: aluWbData = 32'h0;
        endcase
    end

    // Writeback value for a completed memory op, taking load data straight from the memory port.
    always_comb begin
        capIsLoad = regWrite_q && (memToReg_q == 2'b01);
        memWbData = 32'h0;
        case (memToReg_q)
            2'b00: memWbData = addr_q;
            2'b01: memWbData = dmem_rdata;
            2'b10: memWbData = pcAdd4_q;
            2'b11: memWbData = pcAddImm_q;
            default: memWbData = 32'h0;
        endcase
    end

    // State register; reset abandons any in-flight access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: one DONE bubble after the acknowledge before accepting again.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (issueMem) state_d = ACCESS;
            ACCESS:  if (dmem_ack) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Capture the whole bundle of an issued memory op so the request stays stable while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q       <= 1'b0;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            pcAdd4_q   <= 32'h0;
            pcAddImm_q <= 32'h0;
            regWrite_q <= 1'b0;
            memToReg_q <= 2'b00;
            rd_q       <= 5'd0;
        end else if (issueMem) begin
            we_q       <= mem_write;
            addr_q     <= alu_result;
            wdata_q    <= read_data_2;
            pcAdd4_q   <= pc_add4;
            pcAddImm_q <= pc_addimm;
            regWrite_q <= reg_write;
            memToReg_q <= mem_to_reg;
            rd_q       <= reg_write_addr;
        end
    end

    // Writeback and redirect strobes: single-cycle pulses, data fields held between pulses.
    // Memory ops never redirect; the decoder only routes control transfers through the ALU path.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wbValid_q    <= 1'b0;
            wbRegWrite_q <= 1'b0;
            wbAddr_q     <= 5'd0;
            wbData_q     <= 32'h0;
            redirValid_q <= 1'b0;
            redirPc_q    <= 32'h0;
        end else begin
            wbValid_q    <= 1'b0;
            redirValid_q <= 1'b0;
            if (accept && !isMemOp) begin
                wbValid_q    <= 1'b1;
                wbRegWrite_q <= reg_write;
                wbAddr_q     <= reg_write_addr;
                wbData_q     <= aluWbData;
                redirValid_q <= taken;
                redirPc_q    <= redirTarget;
            end else if (accept && misaligned) begin
                wbValid_q    <= 1'b1;
                wbRegWrite_q <= 1'b0;
                wbAddr_q     <= reg_write_addr;
                wbData_q     <= 32'h0;
            end else if ((state_q == ACCESS) && dmem_ack) begin
                wbValid_q    <= 1'b1;
                wbRegWrite_q <= regWrite_q && !(capIsLoad && (rd_q == 5'd0));
                wbAddr_q     <= rd_q;
                wbData_q     <= memWbData;
            end
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    logic misalign_q;

    // One-cycle error pulse for a rejected misaligned memory op.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= accept && misaligned;
        end
    end

    assign misalign_err = misalign_q;
    assign dmem_addr    = addr_q;
`else
    assign misalign_err = 1'b0;
    assign dmem_addr    = {addr_q[31:2], 2'b00};
`endif

    assign stall          = (state_q != IDLE);
    assign dmem_req       = (state_q == ACCESS);
    assign dmem_we        = (state_q == ACCESS) && we_q;
    assign dmem_wdata     = wdata_q;
    assign wb_valid       = wbValid_q;
    assign wb_reg_write   = wbRegWrite_q;
    assign wb_addr        = wbAddr_q;
    assign wb_data        = wbData_q;
    assign redirect_valid = redirValid_q;
    assign redirect_pc    = redirPc_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized bench for mem_stage with a transaction-level reference model.
// Directed sequences pin the model with hand-computed literal values.

module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] alu_result;
    logic [31:0] read_data_2;
    logic [31:0] pc_addimm;
    logic        zero_flag;
    logic [1:0]  pc_src;
    logic        reg_write;
    logic [1:0]  mem_to_reg;
    logic        mem_write;
    logic        branch;
    logic [2:0]  b_type;
    logic [4:0]  reg_write_addr;
    logic [31:0] pc_add4;
    logic        stall;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        wb_valid;
    logic        wb_reg_write;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        misalign_err;

    mem_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .alu_result(alu_result),
        .read_data_2(read_data_2), .pc_addimm(pc_addimm), .zero_flag(zero_flag),
        .pc_src(pc_src), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
        .mem_write(mem_write), .branch(branch), .b_type(b_type),
        .reg_write_addr(reg_write_addr), .pc_add4(pc_add4), .stall(stall),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_addr(wb_addr),
        .wb_data(wb_data), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        valid;
        logic [31:0] alu;
        logic [31:0] wdata;
        logic [31:0] pcImm;
        logic [31:0] pcAdd4;
        logic        zf;
        logic [1:0]  pcSrc;
        logic        regWrite;
        logic [1:0]  memToReg;
        logic        memWrite;
        logic        branch;
        logic [2:0]  bType;
        logic [4:0]  rd;
    } bundle_t;

    typedef struct packed {
        logic        regWrite;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        misalign;
    } wbExp_t;

    // Reference model: expected events keyed by cycle number.
    wbExp_t      expWb [int];
    logic [31:0] expRedir [int];
    int          cyc = 0;
    int          accStart = -10;
    int          accEnd = -10;
    int          doneCycle = -10;
    int          freeCycle = 0;
    int          ackCycle = -10;
    logic [31:0] ackData = 32'h0;
    logic        expWe = 1'b0;
    logic [31:0] expAddr = 32'h0;
    logic [31:0] expWdata = 32'h0;
    bit          checkEn = 1'b0;
    logic        expStall;
    logic        expReq;

    int checks = 0;
    int failures = 0;

    // Observation counters used by the directed sequences.
    int          stallCnt, wbCnt, wbRun, maxWbRun, redirCnt, reqCnt, reqWeCnt, misCnt;
    logic [31:0] lastWbData, lastRedirPc, lastReqAddr;
    logic [4:0]  lastWbAddr;
    logic        lastWbRegWrite;

    // Cycle counter advances on every rising edge.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic resetCounters();
        stallCnt = 0; wbCnt = 0; wbRun = 0; maxWbRun = 0; redirCnt = 0;
        reqCnt = 0; reqWeCnt = 0; misCnt = 0;
        lastWbData = 32'h0; lastRedirPc = 32'h0; lastReqAddr = 32'h0;
        lastWbAddr = 5'd0; lastWbRegWrite = 1'b0;
    endtask

    // Compare DUT outputs against the model on every cycle, away from the rising edge.
    always @(negedge clk) begin
        if (checkEn) begin
            expStall = (cyc >= accStart) && (cyc <= doneCycle);
            expReq   = (cyc >= accStart) && (cyc <= accEnd);
            checkOutput("stall", {31'h0, stall}, {31'h0, expStall});
            checkOutput("dmem_req", {31'h0, dmem_req}, {31'h0, expReq});
            if (expReq) begin
                checkOutput("dmem_we", {31'h0, dmem_we}, {31'h0, expWe});
                checkOutput("dmem_addr", dmem_addr, expAddr);
                if (expWe) checkOutput("dmem_wdata", dmem_wdata, expWdata);
            end
            checkOutput("wb_valid", {31'h0, wb_valid}, {31'h0, expWb.exists(cyc)});
            if (expWb.exists(cyc)) begin
                checkOutput("wb_reg_write", {31'h0, wb_reg_write}, {31'h0, expWb[cyc].regWrite});
                checkOutput("wb_addr", {27'h0, wb_addr}, {27'h0, expWb[cyc].addr});
                checkOutput("wb_data", wb_data, expWb[cyc].data);
                checkOutput("misalign_err", {31'h0, misalign_err}, {31'h0, expWb[cyc].misalign});
            end else begin
                checkOutput("misalign_err", {31'h0, misalign_err}, 32'h0);
            end
            checkOutput("redirect_valid", {31'h0, redirect_valid}, {31'h0, expRedir.exists(cyc)});
            if (expRedir.exists(cyc)) checkOutput("redirect_pc", redirect_pc, expRedir[cyc]);

            stallCnt += int'(stall);
            misCnt   += int'(misalign_err);
            if (dmem_req) begin
                reqCnt++;
                lastReqAddr = dmem_addr;
                if (dmem_we) reqWeCnt++;
            end
            if (wb_valid) begin
                wbCnt++;
                wbRun++;
                if (wbRun > maxWbRun) maxWbRun = wbRun;
                lastWbData = wb_data;
                lastWbAddr = wb_addr;
                lastWbRegWrite = wb_reg_write;
            end else begin
                wbRun = 0;
            end
            if (redirect_valid) begin
                redirCnt++;
                lastRedirPc = redirect_pc;
            end
        end
    end

    function automatic logic [31:0] selectWb(input bundle_t b, input logic [31:0] loadVal);
        case (b.memToReg)
            2'b00:   return b.alu;
            2'b01:   return loadVal;
            2'b10:   return b.pcAdd4;
            default: return b.pcImm;
        endcase
    endfunction

    function automatic bit isTaken(input bundle_t b);
        if (b.pcSrc == 2'b10 || b.pcSrc == 2'b11) return 1'b1;
        if (b.pcSrc == 2'b01 && b.branch) begin
            if (b.bType == 3'd0) return b.zf;
            if (b.bType == 3'd1) return !b.zf;
        end
        return 1'b0;
    endfunction

    // Model update for a bundle accepted in the current cycle; w = memory wait cycles before ack.
    task automatic modelAccept(input bundle_t b, input int w, input logic [31:0] rdat);
        bit     load, memOp;
        wbExp_t e;
        if (!b.valid) return;
        load  = b.regWrite && (b.memToReg == 2'b01);
        memOp = b.memWrite || load;
`ifdef MEM_ALIGN_CHECK_EN
        if (memOp && (b.alu[1:0] != 2'b00)) begin
            e.regWrite = 1'b0; e.addr = b.rd; e.data = 32'h0; e.misalign = 1'b1;
            expWb[cyc + 1] = e;
            return;
        end
`endif
        if (memOp) begin
            accStart  = cyc + 1;
            accEnd    = cyc + 1 + w;
            doneCycle = accEnd + 1;
            freeCycle = doneCycle + 1;
            ackCycle  = accEnd;
            ackData   = rdat;
            expWe     = b.memWrite;
            expAddr   = b.alu & 32'hFFFF_FFFC;
            expWdata  = b.wdata;
            e.regWrite = b.regWrite && !(load && (b.rd == 5'd0));
            e.addr = b.rd; e.data = selectWb(b, rdat); e.misalign = 1'b0;
            expWb[doneCycle] = e;
        end else begin
            e.regWrite = b.regWrite; e.addr = b.rd; e.data = selectWb(b, 32'h0); e.misalign = 1'b0;
            expWb[cyc + 1] = e;
            if (isTaken(b)) expRedir[cyc + 1] = (b.pcSrc == 2'b11) ? (b.alu & 32'hFFFF_FFFE) : b.pcImm;
        end
    endtask

    // Memory responder plus one clock step: ack exactly when scheduled, random stray acks outside the access window.
    task automatic stepCycle();
        if (cyc == ackCycle) begin
            dmem_ack = 1'b1;
            dmem_rdata = ackData;
        end else begin
            dmem_rdata = $urandom;
            dmem_ack = !((cyc >= accStart) && (cyc <= accEnd)) && ($urandom_range(0, 3) == 0);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic driveBundle(input bundle_t b);
        in_valid = b.valid; alu_result = b.alu; read_data_2 = b.wdata; pc_addimm = b.pcImm;
        pc_add4 = b.pcAdd4; zero_flag = b.zf; pc_src = b.pcSrc; reg_write = b.regWrite;
        mem_to_reg = b.memToReg; mem_write = b.memWrite; branch = b.branch; b_type = b.bType;
        reg_write_addr = b.rd;
    endtask

    // Present a bundle and hold it until the model says the stage can take it.
    task automatic applyStimulus(input bundle_t b, input int w, input logic [31:0] rdat);
        driveBundle(b);
        for (int guard = 0; guard < 50; guard++) begin
            if (!b.valid || cyc >= freeCycle) begin
                modelAccept(b, w, rdat);
                stepCycle();
                return;
            end
            stepCycle();
        end
        checks++;
        failures++;
        $display("[TB] FAIL accept_timeout: got stalled expected accepted (cycle %0d)", cyc);
    endtask

    function automatic bundle_t makeOp();
        bundle_t b;
        b = '0;
        b.valid = 1'b1;
        b.pcAdd4 = 32'h0000_1004;
        b.pcImm = 32'h0000_2000;
        return b;
    endfunction

    function automatic bundle_t randBundle();
        bundle_t b;
        int kind;
        b.valid    = ($urandom_range(0, 9) != 0);
        b.alu      = $urandom;
        b.wdata    = $urandom;
        b.pcImm    = $urandom;
        b.pcAdd4   = $urandom;
        b.zf       = 1'($urandom_range(0, 1));
        b.bType    = 3'($urandom_range(0, 2));
        b.branch   = 1'($urandom_range(0, 1));
        b.rd       = 5'($urandom_range(0, 31));
        b.pcSrc    = 2'($urandom_range(0, 3));
        b.regWrite = 1'($urandom_range(0, 1));
        b.memToReg = 2'($urandom_range(0, 3));
        b.memWrite = 1'b0;
        kind = int'($urandom_range(0, 3));
        if (kind == 0) begin
            b.regWrite = 1'b1; b.memToReg = 2'b01; b.pcSrc = 2'b00;
        end else if (kind == 1) begin
            b.memWrite = 1'b1; b.regWrite = 1'b0; b.pcSrc = 2'b00;
        end else if (b.regWrite && b.memToReg == 2'b01) begin
            b.memToReg = 2'b00;
        end
        if (kind <= 1 && $urandom_range(0, 3) != 0) b.alu[1:0] = 2'b00;
        return b;
    endfunction

    task automatic idleCycles(input int n);
        bundle_t b;
        for (int i = 0; i < n; i++) begin
            b = randBundle();
            b.valid = 1'b0;
            driveBundle(b);
            stepCycle();
        end
    endtask

    // Hard time limit so the run always ends with a summary.
    initial begin
        #2000000;
        failures++;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        bundle_t b;
        rst = 1'b1;
        dmem_ack = 1'b0;
        dmem_rdata = 32'h0;
        driveBundle('0);
        resetCounters();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_stall", {31'h0, stall}, 32'h0);
        checkOutput("reset_wb_valid", {31'h0, wb_valid}, 32'h0);
        checkOutput("reset_wb_data", wb_data, 32'h0);
        checkOutput("reset_dmem_req", {31'h0, dmem_req}, 32'h0);
        checkOutput("reset_redirect", {31'h0, redirect_valid}, 32'h0);
        checkOutput("reset_redirect_pc", redirect_pc, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkEn = 1'b1;
        idleCycles(2);

        // Load with two wait cycles.
        resetCounters();
        b = makeOp(); b.alu = 32'h100; b.regWrite = 1'b1; b.memToReg = 2'b01; b.rd = 5'd5;
        applyStimulus(b, 2, 32'hDEAD_BEEF);
        idleCycles(6);
        checkOutput("load_stall_cycles", stallCnt, 32'd4);
        checkOutput("load_wb_count", wbCnt, 32'd1);
        checkOutput("load_wb_addr", {27'h0, lastWbAddr}, 32'd5);
        checkOutput("load_wb_data", lastWbData, 32'hDEAD_BEEF);

        // Store with immediate ack.
        resetCounters();
        b = makeOp(); b.alu = 32'h200; b.wdata = 32'h1234_5678; b.memWrite = 1'b1;
        applyStimulus(b, 0, 32'h0);
        idleCycles(4);
        checkOutput("store_we_cycles", reqWeCnt, 32'd1);
        checkOutput("store_req_addr", lastReqAddr, 32'h200);
        checkOutput("store_wb_count", wbCnt, 32'd1);
        checkOutput("store_wb_reg_write", {31'h0, lastWbRegWrite}, 32'h0);
        checkOutput("store_stall_cycles", stallCnt, 32'd2);

        // beq taken, bne not taken, then jalr with odd target.
        resetCounters();
        b = makeOp(); b.pcSrc = 2'b01; b.branch = 1'b1; b.bType = 3'd0; b.zf = 1'b1; b.pcImm = 32'h40;
        applyStimulus(b, 0, 32'h0);
        b.bType = 3'd1; b.pcImm = 32'h80;
        applyStimulus(b, 0, 32'h0);
        idleCycles(3);
        checkOutput("branch_redirect_count", redirCnt, 32'd1);
        checkOutput("branch_redirect_pc", lastRedirPc, 32'h40);
        resetCounters();
        b = makeOp(); b.pcSrc = 2'b11; b.alu = 32'h81; b.regWrite = 1'b1; b.memToReg = 2'b10; b.rd = 5'd1;
        applyStimulus(b, 0, 32'h0);
        idleCycles(2);
        checkOutput("jalr_redirect_count", redirCnt, 32'd1);
        checkOutput("jalr_redirect_pc", lastRedirPc, 32'h80);
        checkOutput("jalr_wb_data", lastWbData, 32'h1004);

        // Three back-to-back ALU ops.
        resetCounters();
        for (int i = 1; i <= 3; i++) begin
            b = makeOp(); b.regWrite = 1'b1; b.rd = 5'(i); b.alu = 32'(i * 11);
            applyStimulus(b, 0, 32'h0);
        end
        idleCycles(2);
        checkOutput("alu_stall_cycles", stallCnt, 32'd0);
        checkOutput("alu_wb_count", wbCnt, 32'd3);
        checkOutput("alu_wb_run", maxWbRun, 32'd3);
        checkOutput("alu_last_wb_data", lastWbData, 32'd33);

        // Misaligned load address.
        resetCounters();
        b = makeOp(); b.alu = 32'h102; b.regWrite = 1'b1; b.memToReg = 2'b01; b.rd = 5'd7;
        applyStimulus(b, 1, 32'hCAFE_0001);
        idleCycles(5);
`ifdef MEM_ALIGN_CHECK_EN
        checkOutput("misalign_req_count", reqCnt, 32'd0);
        checkOutput("misalign_pulses", misCnt, 32'd1);
        checkOutput("misalign_wb_reg_write", {31'h0, lastWbRegWrite}, 32'h0);
`else
        checkOutput("misalign_req_addr", lastReqAddr, 32'h100);
        checkOutput("misalign_pulses", misCnt, 32'd0);
        checkOutput("misalign_wb_data", lastWbData, 32'hCAFE_0001);
`endif

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            applyStimulus(randBundle(), int'($urandom_range(0, 3)), $urandom);
        end
        idleCycles(8);

        // Reset in the middle of an access; the later ack must be ignored.
        b = makeOp(); b.alu = 32'h300; b.regWrite = 1'b1; b.memToReg = 2'b01; b.rd = 5'd9;
        applyStimulus(b, 6, 32'h5555_AAAA);
        idleCycles(1);
        checkOutput("midaccess_req", {31'h0, dmem_req}, 32'h1);
        checkEn = 1'b0;
        #2;
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rst_stall", {31'h0, stall}, 32'h0);
        checkOutput("rst_dmem_req", {31'h0, dmem_req}, 32'h0);
        checkOutput("rst_dmem_addr", dmem_addr, 32'h0);
        checkOutput("rst_wb_valid", {31'h0, wb_valid}, 32'h0);
        checkOutput("rst_wb_data", wb_data, 32'h0);
        checkOutput("rst_wb_addr", {27'h0, wb_addr}, 32'h0);
        checkOutput("rst_redirect_pc", redirect_pc, 32'h0);
        checkOutput("rst_misalign", {31'h0, misalign_err}, 32'h0);
        if (expWb.exists(doneCycle)) expWb.delete(doneCycle);
        accStart = -10; accEnd = -10; doneCycle = -10; freeCycle = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        resetCounters();
        checkEn = 1'b1;
        idleCycles(10);
        checkOutput("postrst_wb_count", wbCnt, 32'd0);
        checkOutput("postrst_stall_cycles", stallCnt, 32'd0);
        checkOutput("postrst_req_count", reqCnt, 32'd0);

        checkEn = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
